// File: rtl/md_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the operation codes and FSM state encoding.
package md_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MdIdle = 2'b00,
    MdCalc = 2'b01,
    MdFix  = 2'b10
  } md_state_e;

  // Opcode bit 0 clear means signed; bit 1 set means divide.
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_negate.sv
// Combinational conditional two's-complement negation.
module md_negate #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] in_i,
  input  logic             en_i,
  output logic [Width-1:0] out_o
);

  assign out_o = en_i ? ((~in_i) + Width'(1)) : in_i;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       md_op_i,
  input  logic [Width-1:0] bus_a_i,
  input  logic [Width-1:0] bus_b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [Width-1:0] wr_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  md_state_e          state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [Width-1:0]   opa_q, opa_d;
  logic [Width-1:0]   opb_q, opb_d;
  logic [Width-1:0]   orig_a_q, orig_a_d;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [Width-1:0]   rem_q, rem_d;
  logic               psign_q, psign_d;
  logic               rsign_q, rsign_d;
  logic               dz_flag_q, dz_flag_d;
  logic [Width-1:0]   hi_q, hi_d;
  logic [Width-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_out_q, dz_out_d;

  logic               in_signed;
  logic [Width-1:0]   mag_a, mag_b;
  logic [2*Width-1:0] prod_fix;
  logic [Width-1:0]   quot_fix, rem_fix;
  logic [Width:0]     mul_sum;
  logic [Width:0]     div_shift;
  logic [Width-1:0]   div_diff;
  logic               div_ge;

  assign in_signed = md_is_signed(md_op_i);

  md_negate #(.Width(Width)) u_neg_a (
    .in_i  (bus_a_i),
    .en_i  (in_signed & bus_a_i[Width-1]),
    .out_o (mag_a)
  );

  md_negate #(.Width(Width)) u_neg_b (
    .in_i  (bus_b_i),
    .en_i  (in_signed & bus_b_i[Width-1]),
    .out_o (mag_b)
  );

  md_negate #(.Width(2 * Width)) u_neg_prod (
    .in_i  (acc_q),
    .en_i  (psign_q),
    .out_o (prod_fix)
  );

  md_negate #(.Width(Width)) u_neg_quot (
    .in_i  (acc_q[Width-1:0]),
    .en_i  (psign_q),
    .out_o (quot_fix)
  );

  md_negate #(.Width(Width)) u_neg_rem (
    .in_i  (rem_q),
    .en_i  (rsign_q),
    .out_o (rem_fix)
  );

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum   = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  // Divide: acc[Width-1:0] shifts dividend bits out and quotient bits in.
  assign div_shift = {rem_q, acc_q[Width-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_diff  = div_shift[Width-1:0] - opb_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    orig_a_d  = orig_a_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    psign_d   = psign_q;
    rsign_d   = rsign_q;
    dz_flag_d = dz_flag_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_out_d  = 1'b0;

    unique case (state_q)
      MdIdle: begin
        if (start_i) begin
          op_d      = md_op_i;
          opa_d     = mag_a;
          opb_d     = mag_b;
          orig_a_d  = bus_a_i;
          psign_d   = in_signed & (bus_a_i[Width-1] ^ bus_b_i[Width-1]);
          rsign_d   = in_signed & bus_a_i[Width-1];
          dz_flag_d = md_op_i[1] & (bus_b_i == '0);
          acc_d     = md_op_i[1] ? {{Width{1'b0}}, mag_a} : {{Width{1'b0}}, mag_b};
          rem_d     = '0;
          count_d   = '0;
          state_d   = MdCalc;
        end else begin
          if (hi_we_i) hi_d = wr_data_i;
          if (lo_we_i) lo_d = wr_data_i;
        end
      end
      MdCalc: begin
        if (op_q[1]) begin
          rem_d = div_ge ? div_diff : div_shift[Width-1:0];
          acc_d = {acc_q[2*Width-1:Width], acc_q[Width-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[Width-1:1]};
        end
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(Width - 1)) state_d = MdFix;
      end
      MdFix: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_flag_q) begin
          hi_d = orig_a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        done_d   = 1'b1;
        dz_out_d = dz_flag_q;
        state_d  = MdIdle;
      end
      default: state_d = MdIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= MdIdle;
      op_q      <= MD_MULT;
      count_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      orig_a_q  <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      psign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      dz_flag_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      orig_a_q  <= orig_a_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      psign_q   <= psign_d;
      rsign_q   <= rsign_d;
      dz_flag_q <= dz_flag_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_out_q  <= dz_out_d;
    end
  end

  assign busy_o     = (state_q != MdIdle);
  assign done_o     = done_q;
  assign div_zero_o = dz_out_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_md_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  md_unit #(.Width(32), .CntW(5)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .md_op_i    (md_op),
    .bus_a_i    (bus_a),
    .bus_b_i    (bus_b),
    .hi_we_i    (hi_we),
    .lo_we_i    (lo_we),
    .wr_data_i  (wr_data),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (div_zero),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; C-style truncating division.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ez = 1'b0;
    eh = '0;
    el = '0;
    case (op)
      2'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'd1: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; ez = 1'b1;
        end else if (op == 2'd2) begin
          q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0];
        end else begin
          eh = a % b; el = a / b;
        end
      end
    endcase
  endtask

  // Called at a negedge; asserts Start for one cycle.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit with_lo_we);
    start = 1'b1; md_op = op; bus_a = a; bus_b = b;
    lo_we = with_lo_we; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    md_op = 2'($urandom); bus_a = $urandom; bus_b = $urandom;
  endtask

  // Called at the negedge after edge 0; returns at the Done negedge.
  task automatic wait_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit inject);
    logic [31:0] eh, el;
    logic        ez;
    int          busy_n;
    bit          seen;
    model(op, a, b, eh, el, ez);
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_done_low"}, done, 0);
    busy_n = 0;
    seen   = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) busy_n++;
        if (inject && busy_n == 10) begin
          start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wr_data = $urandom;
          md_op = 2'd1; bus_a = $urandom; bus_b = $urandom;
        end else begin
          start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_busy_cycles"}, busy_n, 33);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_divzero"}, div_zero, ez);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    start_op(op, a, b, 0);
    wait_check(tag, op, a, b, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; md_op = 2'd0; bus_a = '0; bus_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_divzero", div_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5);
    chk("mult_neg_hi_c", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo_c", lo, 32'hFFFF_FFF1);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi_c", hi, 32'hFFFF_FFFE);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo_c", lo, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'd3, 32'd100, 32'd0);
    run_op("div_zero_s", 2'd2, 32'h8000_0005, 32'd0);

    // Back-to-back: second Start issued in the Done cycle.
    start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    wait_check("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    start_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0);
    wait_check("b2b_mult", 2'd0, 32'h8000_0000, 32'h8000_0000, 0);
    @(negedge clk);

    hi_we = 1'b1; wr_data = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi, 32'h0000_1234);
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h5555_AAAA;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both_hi", hi, 32'h5555_AAAA);
    chk("mt_both_lo", lo, 32'h5555_AAAA);

    // Start with LoWe in the same cycle, and a stray Start/MT write mid-operation.
    start_op(2'd3, 32'd7, 32'd2, 1);
    chk("lowe_discard", lo, 32'h5555_AAAA);
    wait_check("divu_7_2", 2'd3, 32'd7, 32'd2, 1);
    @(negedge clk);

    // Reset mid-operation.
    start_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    run_op("multu_6_7", 2'd1, 32'd6, 32'd7);
    chk("multu_6_7_lo_c", lo, 32'd42);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = {28'd0, 4'($urandom)};
        default: ;
      endcase
      run_op("rand", rop, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
